// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads to instruction memory and
// buffers returned words with their addresses until decode accepts them.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [AW-1:0]            imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_pc,
   output logic                     id_valid,
   output logic [31:0]              id_instr,
   output logic [AW-1:0]            id_pc_inc,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]   instr;
      logic [AW-1:0] pc;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]   pending_pc_q, pending_pc_d;
   logic            pending_q, pending_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            issue, push, pop, nonempty;
   logic [CW:0]     credit;
   entry_t          head;

   // Outstanding request counts against capacity so a response always has a slot.
   assign credit   = {1'b0, count_q} + (CW+1)'(pending_q);
   assign nonempty = (count_q != '0);
   assign issue    = !reset && !redirect && (credit < (CW+1)'(DEPTH));
   assign push     = !reset && !redirect && pending_q;
   assign pop      = !reset && !redirect && nonempty && id_ready;
   assign head     = mem_q[rd_ptr_q];

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign id_valid  = !reset && nonempty;
   assign id_instr  = id_valid ? head.instr : 32'h0;
   assign id_pc_inc = id_valid ? head.pc + AW'(4) : '0;
   assign count     = reset ? '0 : count_q;

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pending_d    = 1'b0;
      pending_pc_d = pending_pc_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      if (redirect) begin
         // Word-align the target; anything in flight or buffered is dropped.
         fetch_pc_d = redirect_pc & ~AW'(3);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d   = fetch_pc_q + AW'(4);
            pending_d    = 1'b1;
            pending_pc_d = fetch_pc_q;
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= '0;
         pending_q    <= 1'b0;
         pending_pc_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pending_q    <= pending_d;
         pending_pc_q <= pending_pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: count gates visibility of every slot.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: pending_pc_q};
   end

endmodule
